// File: rtl/ibex_alu_stim_seq.sv
// LFSR-driven stimulus sequencer and self-checker placed upstream of ibex_alu.
// Optional first-failure capture ports are enabled by defining ALU_STIM_FAIL_CAPTURE_EN.
package ibex_alu_stim_pkg;
  typedef enum logic [6:0] {
    ALU_ADD = 7'd0,
    ALU_SUB = 7'd1,
    ALU_XOR = 7'd2,
    ALU_OR  = 7'd3,
    ALU_AND = 7'd4,
    ALU_LT  = 7'd25,
    ALU_LTU = 7'd26,
    ALU_GE  = 7'd27,
    ALU_GEU = 7'd28,
    ALU_EQ  = 7'd29,
    ALU_NE  = 7'd30
  } alu_op_e;
endpackage

module ibex_alu_stim_seq
  import ibex_alu_stim_pkg::*;
#(
  parameter int unsigned NUM_VEC     = 150,
  parameter int unsigned MAX_VAL     = 20,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2026
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  alu_op_e     operator_sel_i,
  input  logic        equal_mode_i,
  output alu_op_e     operator_o,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  output logic        instr_first_cycle_o,
  output logic        multdiv_sel_o,
  output logic        valid_o,
  input  logic [31:0] result_i,
  input  logic        comparison_result_i,
  input  logic        is_equal_result_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] vec_count_o,
  output logic [15:0] mismatch_count_o
`ifdef ALU_STIM_FAIL_CAPTURE_EN
  ,
  output logic [15:0] first_fail_idx_o,
  output logic [31:0] first_fail_a_o,
  output logic [31:0] first_fail_b_o,
  output logic        first_fail_vld_o
`endif
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [15:0] VEC_LAST  = 16'(NUM_VEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  function automatic logic [7:0] bound_op(input logic [7:0] x);
    return 8'(x % 8'(MAX_VAL)) + 8'd1;
  endfunction

  function automatic logic vec_ok(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] res, input logic cmp, input logic iseq);
    logic ok;
    ok = 1'b1;
    case (op)
      ALU_EQ:  ok = (iseq == (a == b)) && (cmp == (a == b));
      ALU_NE:  ok = (cmp == (a != b));
      ALU_ADD: ok = (res == (a + b));
      ALU_SUB: ok = (res == (a - b));
      ALU_XOR: ok = (res == (a ^ b));
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  state_e      r_state;
  logic [31:0] r_lfsr;
  alu_op_e     r_op;
  logic        r_eq;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;
  logic        r_first;
  logic [3:0]  r_hold;
  logic [15:0] r_vec_cnt;
  logic [15:0] r_mis_cnt;
`ifdef ALU_STIM_FAIL_CAPTURE_EN
  logic [15:0] r_ff_idx;
  logic [31:0] r_ff_a;
  logic [31:0] r_ff_b;
  logic        r_ff_vld;
`endif

  logic [31:0] w_lfsr_step2;
  logic [31:0] w_src;
  logic        w_src_eq;
  logic [7:0]  w_load_a;
  logic [7:0]  w_load_b;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic        w_sample;
  logic        w_last;
  logic        w_ok;

  assign w_lfsr_step2 = lfsr_step(lfsr_step(r_lfsr));
  assign w_op_a       = {24'd0, r_a};
  assign w_op_b       = {24'd0, r_b};
  assign w_sample     = (r_state == S_DRIVE) && (r_hold == HOLD_LAST);
  assign w_last       = w_sample && (r_vec_cnt == VEC_LAST);
  assign w_ok         = vec_ok(r_op, w_op_a, w_op_b, result_i, comparison_result_i, is_equal_result_i);

  // Next vector: the first comes from the current LFSR, later ones from the double-stepped state.
  always_comb begin
    w_src    = r_lfsr;
    w_src_eq = equal_mode_i;
    if (r_state == S_DRIVE) begin
      w_src    = w_lfsr_step2;
      w_src_eq = r_eq;
    end else begin
      w_src    = r_lfsr;
      w_src_eq = equal_mode_i;
    end
    w_load_a = bound_op(w_src[7:0]);
    w_load_b = w_src_eq ? w_load_a : bound_op(w_src[15:8]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_lfsr    <= LFSR_SEED;
      r_op      <= ALU_ADD;
      r_eq      <= 1'b0;
      r_a       <= 8'd0;
      r_b       <= 8'd0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_first   <= 1'b0;
      r_hold    <= 4'd0;
      r_vec_cnt <= 16'd0;
      r_mis_cnt <= 16'd0;
`ifdef ALU_STIM_FAIL_CAPTURE_EN
      r_ff_idx  <= 16'd0;
      r_ff_a    <= 32'd0;
      r_ff_b    <= 32'd0;
      r_ff_vld  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_state   <= S_DRIVE;
            r_op      <= operator_sel_i;
            r_eq      <= equal_mode_i;
            r_a       <= w_load_a;
            r_b       <= w_load_b;
            r_valid   <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_first   <= 1'b1;
            r_hold    <= 4'd0;
            r_vec_cnt <= 16'd0;
            r_mis_cnt <= 16'd0;
`ifdef ALU_STIM_FAIL_CAPTURE_EN
            r_ff_idx  <= 16'd0;
            r_ff_a    <= 32'd0;
            r_ff_b    <= 32'd0;
            r_ff_vld  <= 1'b0;
`endif
          end
        end
        S_DRIVE: begin
          if (w_sample) begin
            r_vec_cnt <= r_vec_cnt + 16'd1;
            r_lfsr    <= w_lfsr_step2;
            if (!w_ok && (r_mis_cnt != 16'hFFFF)) begin
              r_mis_cnt <= r_mis_cnt + 16'd1;
            end
`ifdef ALU_STIM_FAIL_CAPTURE_EN
            if (!w_ok && !r_ff_vld) begin
              r_ff_idx <= r_vec_cnt;
              r_ff_a   <= w_op_a;
              r_ff_b   <= w_op_b;
              r_ff_vld <= 1'b1;
            end
`endif
            // Operands are left untouched on the final vector so they hold in DONE.
            if (w_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_first <= 1'b0;
              r_hold  <= 4'd0;
            end else begin
              r_a     <= w_load_a;
              r_b     <= w_load_b;
              r_first <= 1'b1;
              r_hold  <= 4'd0;
            end
          end else begin
            r_hold  <= r_hold + 4'd1;
            r_first <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign operator_o          = r_op;
  assign operand_a_o         = w_op_a;
  assign operand_b_o         = w_op_b;
  assign instr_first_cycle_o = r_first;
  assign multdiv_sel_o       = 1'b0;
  assign valid_o             = r_valid;
  assign busy_o              = r_busy;
  assign done_o              = r_done;
  assign vec_count_o         = r_vec_cnt;
  assign mismatch_count_o    = r_mis_cnt;
`ifdef ALU_STIM_FAIL_CAPTURE_EN
  assign first_fail_idx_o    = r_ff_idx;
  assign first_fail_a_o      = r_ff_a;
  assign first_fail_b_o      = r_ff_b;
  assign first_fail_vld_o    = r_ff_vld;
`endif

endmodule

// File: tb/tb_ibex_alu_stim_seq.sv
// Bench for ibex_alu_stim_seq: acts as the ALU, models the LFSR operand stream and run counters.
module tb_ibex_alu_stim_seq;
  import ibex_alu_stim_pkg::*;

  localparam int          NV   = 150;
  localparam int          MV   = 20;
  localparam logic [31:0] SEED = 32'hACE1_2026;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic    rst_i = 1'b1;
  logic    start_i = 1'b0;
  alu_op_e op_sel = ALU_ADD;
  logic    eq_sel = 1'b0;
  int      cur_idx = -1;
  int      g_inj_idx = -1;
  int      g_inj_kind = 0;

  alu_op_e     d_op;
  logic [31:0] d_a, d_b, d_res;
  logic        d_first, d_md, d_valid, d_cmp, d_iseq, d_busy, d_done;
  logic [15:0] d_vec, d_mis;

  logic        h_start = 1'b0;
  alu_op_e     h_op;
  logic [31:0] h_a, h_b, h_res;
  logic        h_first, h_md, h_valid, h_cmp, h_iseq, h_busy, h_done;
  logic [15:0] h_vec, h_mis;
`ifdef ALU_STIM_FAIL_CAPTURE_EN
  logic [15:0] d_ffi, h_ffi;
  logic [31:0] d_ffa, d_ffb, h_ffa, h_ffb;
  logic        d_ffv, h_ffv;
`endif

  ibex_alu_stim_seq u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .operator_sel_i(op_sel),
    .equal_mode_i(eq_sel), .operator_o(d_op), .operand_a_o(d_a), .operand_b_o(d_b),
    .instr_first_cycle_o(d_first), .multdiv_sel_o(d_md), .valid_o(d_valid),
    .result_i(d_res), .comparison_result_i(d_cmp), .is_equal_result_i(d_iseq),
    .busy_o(d_busy), .done_o(d_done), .vec_count_o(d_vec), .mismatch_count_o(d_mis)
`ifdef ALU_STIM_FAIL_CAPTURE_EN
    , .first_fail_idx_o(d_ffi), .first_fail_a_o(d_ffa), .first_fail_b_o(d_ffb),
    .first_fail_vld_o(d_ffv)
`endif
  );

  ibex_alu_stim_seq #(.HOLD_CYCLES(3)) u_h3 (
    .clk_i(clk), .rst_i(rst_i), .start_i(h_start), .operator_sel_i(ALU_ADD),
    .equal_mode_i(1'b0), .operator_o(h_op), .operand_a_o(h_a), .operand_b_o(h_b),
    .instr_first_cycle_o(h_first), .multdiv_sel_o(h_md), .valid_o(h_valid),
    .result_i(h_res), .comparison_result_i(h_cmp), .is_equal_result_i(h_iseq),
    .busy_o(h_busy), .done_o(h_done), .vec_count_o(h_vec), .mismatch_count_o(h_mis)
`ifdef ALU_STIM_FAIL_CAPTURE_EN
    , .first_fail_idx_o(h_ffi), .first_fail_a_o(h_ffa), .first_fail_b_o(h_ffb),
    .first_fail_vld_o(h_ffv)
`endif
  );

  function automatic logic [33:0] alu_model(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c;
    r = 32'd0;
    c = 1'b0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_XOR: r = a ^ b;
      ALU_OR:  r = a | b;
      ALU_AND: r = a & b;
      ALU_LT:  c = $signed(a) < $signed(b);
      ALU_LTU: c = a < b;
      ALU_GE:  c = $signed(a) >= $signed(b);
      ALU_GEU: c = a >= b;
      ALU_EQ:  c = (a == b);
      ALU_NE:  c = (a != b);
      default: r = 32'd0;
    endcase
    return {(a == b), c, r};
  endfunction

  // ALU stand-in with fault injection on one chosen vector.
  always_comb begin
    logic [33:0] w;
    w      = alu_model(d_op, d_a, d_b);
    d_res  = w[31:0];
    d_cmp  = w[32];
    d_iseq = w[33];
    if (d_valid && (cur_idx == g_inj_idx)) begin
      if (g_inj_kind == 1) d_iseq = 1'b0;
      if (g_inj_kind == 2 || g_inj_kind == 4) d_res[0] = ~d_res[0];
      if (g_inj_kind == 3 || g_inj_kind == 4) d_cmp = ~d_cmp;
      if (g_inj_kind == 4) d_iseq = ~d_iseq;
    end
  end

  always_comb begin
    logic [33:0] w;
    w      = alu_model(h_op, h_a, h_b);
    h_res  = w[31:0];
    h_cmp  = w[32];
    h_iseq = w[33];
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [31:0] bnd(input logic [7:0] x);
    return 32'((int'(x) % MV) + 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [31:0] m_lfsr = SEED;

  task automatic chk_reset_state(input string tag);
    chk({tag, " valid"}, 32'(d_valid), 32'd0);
    chk({tag, " busy"}, 32'(d_busy), 32'd0);
    chk({tag, " done"}, 32'(d_done), 32'd0);
    chk({tag, " first"}, 32'(d_first), 32'd0);
    chk({tag, " op"}, 32'(d_op), 32'(ALU_ADD));
    chk({tag, " a"}, d_a, 32'd0);
    chk({tag, " b"}, d_b, 32'd0);
    chk({tag, " vec"}, 32'(d_vec), 32'd0);
    chk({tag, " mis"}, 32'(d_mis), 32'd0);
    chk({tag, " md"}, 32'(d_md), 32'd0);
  endtask

  task automatic do_run(input alu_op_e op, input logic eq, input int inj_idx, input int inj_kind,
                        input int exp_mis, input int pulse_at, input int reset_at);
    logic [31:0] ma, mb, ra, rb;
    string t;
    ra = 32'd0;
    rb = 32'd0;
    ma = 32'd0;
    mb = 32'd0;
    op_sel     = op;
    eq_sel     = eq;
    g_inj_idx  = inj_idx;
    g_inj_kind = inj_kind;
    start_i    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    op_sel  = ALU_XOR;
    eq_sel  = ~eq;
    for (int i = 0; i < NV; i++) begin
      t       = $sformatf("%s v%0d", op.name(), i);
      cur_idx = i;
      ma = bnd(m_lfsr[7:0]);
      mb = eq ? ma : bnd(m_lfsr[15:8]);
      if (i == inj_idx) begin
        ra = ma;
        rb = mb;
      end
      chk({t, " a"}, d_a, ma);
      chk({t, " b"}, d_b, mb);
      chk({t, " valid"}, 32'(d_valid), 32'd1);
      chk({t, " busy"}, 32'(d_busy), 32'd1);
      chk({t, " first"}, 32'(d_first), 32'd1);
      chk({t, " vec"}, 32'(d_vec), 32'(i));
      chk({t, " op"}, 32'(d_op), 32'(op));
      if (i == reset_at) begin
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_i   = 1'b0;
        cur_idx = -1;
        m_lfsr  = SEED;
        chk_reset_state("midrun reset");
        return;
      end
      start_i = (i == pulse_at);
      @(posedge clk);
      @(negedge clk);
      m_lfsr = lfsr_step(lfsr_step(m_lfsr));
    end
    start_i = 1'b0;
    cur_idx = -1;
    t = $sformatf("%s end", op.name());
    chk({t, " done"}, 32'(d_done), 32'd1);
    chk({t, " valid"}, 32'(d_valid), 32'd0);
    chk({t, " busy"}, 32'(d_busy), 32'd0);
    chk({t, " vec"}, 32'(d_vec), 32'(NV));
    chk({t, " mis"}, 32'(d_mis), 32'(exp_mis));
    chk({t, " a hold"}, d_a, ma);
    chk({t, " b hold"}, d_b, mb);
`ifdef ALU_STIM_FAIL_CAPTURE_EN
    chk({t, " ff vld"}, 32'(d_ffv), 32'(exp_mis > 0));
    if (exp_mis > 0) begin
      chk({t, " ff idx"}, 32'(d_ffi), 32'(inj_idx));
      chk({t, " ff a"}, d_ffa, ra);
      chk({t, " ff b"}, d_ffb, rb);
    end
`endif
    @(negedge clk);
    chk({t, " done level"}, 32'(d_done), 32'd1);
    chk({t, " vec hold"}, 32'(d_vec), 32'(NV));
  endtask

  typedef struct {
    alu_op_e op;
    logic    eq;
    int      inj_idx;
    int      inj_kind;
    int      exp_mis;
  } run_t;

  run_t runs[10];

  initial begin
    logic [31:0] ha, hb;
    runs[0] = '{ALU_EQ,  1'b1, -1,   0, 0};
    runs[1] = '{ALU_NE,  1'b1, -1,   0, 0};
    runs[2] = '{ALU_EQ,  1'b1, 4,    1, 1};
    runs[3] = '{ALU_ADD, 1'b0, -1,   0, 0};
    runs[4] = '{ALU_SUB, 1'b0, 10,   2, 1};
    runs[5] = '{ALU_XOR, 1'b0, -1,   0, 0};
    runs[6] = '{ALU_NE,  1'b0, 0,    3, 1};
    runs[7] = '{ALU_LT,  1'b0, 3,    4, 0};
    runs[8] = '{ALU_ADD, 1'b0, NV-1, 2, 1};
    runs[9] = '{ALU_EQ,  1'b0, -1,   0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");
    chk("reset h3 busy", 32'(h_busy), 32'd0);

    rst_i   = 1'b1;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_i   = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    chk_reset_state("rst+start");

    for (int r = 0; r < 10; r++) begin
      do_run(runs[r].op, runs[r].eq, runs[r].inj_idx, runs[r].inj_kind, runs[r].exp_mis, -1, -1);
    end

    do_run(ALU_EQ, 1'b1, -1, 0, 0, 20, 50);
    @(negedge clk);
    chk("post reset idle valid", 32'(d_valid), 32'd0);
    do_run(ALU_EQ, 1'b1, -1, 0, 0, -1, -1);

    ha = 32'd0;
    hb = 32'd0;
    m_lfsr  = SEED;
    h_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    h_start = 1'b0;
    for (int c = 0; c < 3 * NV; c++) begin
      if (c % 3 == 0) begin
        ha = bnd(m_lfsr[7:0]);
        hb = bnd(m_lfsr[15:8]);
      end
      chk($sformatf("h3 c%0d a", c), h_a, ha);
      chk($sformatf("h3 c%0d b", c), h_b, hb);
      chk($sformatf("h3 c%0d first", c), 32'(h_first), 32'(c % 3 == 0));
      chk($sformatf("h3 c%0d busy", c), 32'(h_busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (c % 3 == 2) m_lfsr = lfsr_step(lfsr_step(m_lfsr));
    end
    chk("h3 end busy", 32'(h_busy), 32'd0);
    chk("h3 end done", 32'(h_done), 32'd1);
    chk("h3 end vec", 32'(h_vec), 32'(NV));
    chk("h3 end mis", 32'(h_mis), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
